// File: rtl/mmc3_sst_pkg.sv
// Shared FSM states and SST register-bus address map for the MMC3 save-state sequencer.
package mmc3_sst_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ARM,
        RD_SET,
        RD_CAP,
        RD_HOLD,
        WR_DATA,
        WR_RISE,
        WR_FALL,
        FINISH
    } state_e;

    localparam logic [7:0] SST_BANK0    = 8'd0;
    localparam logic [7:0] SST_R8000    = 8'd8;
    localparam logic [7:0] SST_RA000    = 8'd9;
    localparam logic [7:0] SST_RA001    = 8'd10;
    localparam logic [7:0] SST_IRQ_BASE = 8'd16;

endpackage

// File: rtl/mmc3_sst_seq_m2_edge_sync.sv
// Synchronizes the asynchronous CPU M2 clock and emits one-clk rise/fall pulses.
// Latency: M2_SYNC+1 clk from an M2 transition to its pulse.
// Backpressure: none; pulses are produced every edge.
module m2_edge_sync #(
    parameter int M2_SYNC = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic m2_i,
    output logic rise_o,
    output logic fall_o
);

    logic [M2_SYNC-1:0] sync_q;
    logic               hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q[0] <= m2_i;
            for (int i = 1; i < M2_SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[M2_SYNC-1];
        end
    end

    assign rise_o = !hist_q &&  sync_q[M2_SYNC-1];
    assign fall_o =  hist_q && !sync_q[M2_SYNC-1];

endmodule

// File: rtl/mmc3_sst_seq.sv
// Walks SST addresses 0..REG_CNT-1, streaming mapper readback (save) or writing host bytes (restore).
// Latency: 3 clk per saved register; each restored register spans one full detected M2 cycle.
// Backpressure: rd_ready / wr_valid stalls wait indefinitely; missing M2 edges abort after TIMEOUT clk.
module mmc3_sst_seq
    import mmc3_sst_pkg::*;
#(
    parameter int REG_CNT = 32,
    parameter int M2_SYNC = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_m2,
    input  logic       start,
    input  logic       dir,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       sst_act,
    output logic       sst_we_reg,
    output logic [7:0] sst_addr,
    output logic [7:0] sst_dato,
    input  logic [7:0] sst_di,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready
);

    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [7:0]      ADDR_LAST = 8'(REG_CNT - 1);

    state_e        state_q, state_d;
    logic          dir_q, dir_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          act_q, act_d;
    logic          we_q, we_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    dato_q, dato_d;
    logic [7:0]    rdat_q, rdat_d;
    logic          rvld_q, rvld_d;
    logic          wrdy_q, wrdy_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic m2_rise, m2_fall;
    logic last, waiting, abort;

    m2_edge_sync #(.M2_SYNC(M2_SYNC)) u_m2_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .m2_i   (cpu_m2),
        .rise_o (m2_rise),
        .fall_o (m2_fall)
    );

    assign last = (addr_q == ADDR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            act_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dato_q  <= '0;
            rdat_q  <= '0;
            rvld_q  <= 1'b0;
            wrdy_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            act_q   <= act_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dato_q  <= dato_d;
            rdat_q  <= rdat_d;
            rvld_q  <= rvld_d;
            wrdy_q  <= wrdy_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        act_d   = act_q;
        we_d    = we_q;
        addr_d  = addr_q;
        dato_d  = dato_q;
        rdat_d  = rdat_q;
        rvld_d  = rvld_q;
        wrdy_d  = wrdy_q;
        tmo_d   = tmo_q;
        waiting = 1'b0;
        abort   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    error_d = 1'b0;
                    addr_d  = SST_BANK0;
                    busy_d  = 1'b1;
                    act_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = ARM;
                end
            end
            // A fall here means the mapper has latched SST mode and locked out CPU writes.
            ARM: begin
                if (m2_fall) begin
                    wrdy_d  = dir_q;
                    state_d = dir_q ? WR_DATA : RD_SET;
                end else begin
                    waiting = 1'b1;
                end
            end
            RD_SET: state_d = RD_CAP;
            RD_CAP: begin
                rdat_d  = sst_di;
                rvld_d  = 1'b1;
                state_d = RD_HOLD;
            end
            RD_HOLD: begin
                if (rd_ready) begin
                    rvld_d = 1'b0;
                    if (last) begin
                        tmo_d   = '0;
                        state_d = FINISH;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        state_d = RD_SET;
                    end
                end
            end
            WR_DATA: begin
                if (wr_valid) begin
                    dato_d  = wr_data;
                    wrdy_d  = 1'b0;
                    we_d    = 1'b1;
                    tmo_d   = '0;
                    state_d = WR_RISE;
                end
            end
            WR_RISE: begin
                if (m2_rise) begin
                    tmo_d   = '0;
                    state_d = WR_FALL;
                end else begin
                    waiting = 1'b1;
                end
            end
            // Holding the strobe until the following fall guarantees a full mapper commit edge.
            WR_FALL: begin
                if (m2_fall) begin
                    we_d = 1'b0;
                    if (last) begin
                        tmo_d   = '0;
                        state_d = FINISH;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        wrdy_d  = 1'b1;
                        state_d = WR_DATA;
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
            FINISH: begin
                if (m2_fall) begin
                    act_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    waiting = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (waiting) begin
            if (tmo_q == TMO_LAST) abort = 1'b1;
            else                   tmo_d = tmo_q + 1'b1;
        end

        if (abort) begin
            error_d = 1'b1;
            we_d    = 1'b0;
            act_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            wrdy_d  = 1'b0;
            rvld_d  = 1'b0;
            state_d = IDLE;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign sst_act    = act_q;
    assign sst_we_reg = we_q;
    assign sst_addr   = addr_q;
    assign sst_dato   = dato_q;
    assign rd_data    = rdat_q;
    assign rd_valid   = rvld_q;
    assign wr_ready   = wrdy_q;

endmodule

// File: doc/mmc3_sst_seq.md
Name: mmc3_sst_seq

Overview:
- Save-state sequencer for MMC3-class mapper register files exposed on the SST register bus (addr 0-7 bank regs, 8-10 control, 16+ IRQ block).
- On command, walks SST addresses 0..REG_CNT-1. In save mode it streams each register's readback to the host. In restore mode it writes host-supplied bytes into the mapper.
- Mapper register writes commit on the falling edge of cpu_m2, so every write is held stable across a detected full M2 cycle. The block sits between the host/menu save-state engine and the mapper's SST bus.

Parameters:
- REG_CNT, 32, number of SST addresses walked (0..REG_CNT-1), 1..256.
- M2_SYNC, 2, synchronizer flops on cpu_m2.
- TIMEOUT, 4096, max clk cycles to wait for each M2 edge before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_m2  in  1  CPU M2, asynchronous to clk
- start  in  1  one-clk command pulse; ignored while busy
- dir  in  1  sampled with start: 0 = save (read), 1 = restore (write)
- busy  out  1  high from accepted start until done
- done  out  1  one-clk pulse at end of walk or abort
- error  out  1  sticky M2 timeout flag; cleared by next accepted start
- sst_act  out  1  SST mode to mapper
- sst_we_reg  out  1  register write strobe to mapper
- sst_addr  out  8  SST register address
- sst_dato  out  8  write data to mapper
- sst_di  in  8  mapper readback, combinational from sst_addr
- rd_data  out  8  save stream data
- rd_valid  out  1  save stream valid
- rd_ready  in  1  save stream ready
- wr_data  in  8  restore stream data
- wr_valid  in  1  restore stream valid
- wr_ready  out  1  restore stream ready

Behaviour:
- Reset: state IDLE; busy, done, error, sst_act, sst_we_reg, rd_valid and wr_ready are 0; sst_addr, sst_dato and rd_data are 0; the address counter and timeout counter are 0. Reset mid-walk aborts immediately with no done pulse, and sst_act drops the next clk.
- M2 edge detect: m2 is synchronized through M2_SYNC flops plus one history flop. fall = history&!sync, rise = !history&sync.
- IDLE: on start, latch dir, clear error, set addr=0, busy=1, go ARM.
- ARM: sst_act=1. Wait for a fall so the mapper has entered SST mode and CPU writes are blocked. Then go RD_SET if dir=0, else WR_DATA.
- RD_SET: one settle clk for sst_addr, then go RD_CAP.
- RD_CAP: rd_data<=sst_di, rd_valid<=1, go RD_HOLD.
- RD_HOLD: hold rd_data and rd_valid until rd_ready. The handshake completes on the clk where valid&ready are both high.
  - If addr==REG_CNT-1, go FINISH.
  - Otherwise addr+1 and go RD_SET.
  - rd_valid falls the clk after acceptance; there is no back-to-back throughput requirement.
- WR_DATA: wr_ready=1. On wr_valid&wr_ready, sst_dato<=wr_data, wr_ready<=0, go WR_RISE.
- WR_RISE: sst_we_reg=1 (asserted while addr and data are stable). Wait for rise, then go WR_FALL.
- WR_FALL: sst_we_reg stays 1. Wait for fall, which guarantees one full mapper negedge sampled stable signals.
  - Then sst_we_reg<=0.
  - If addr==REG_CNT-1, go FINISH; else addr+1 and go WR_DATA.
- FINISH: wait for one more fall with sst_we_reg=0, then sst_act<=0, busy<=0, done pulse, go IDLE.
- Address is 8 bits with no wrap past REG_CNT-1. REG_CNT=1 walks address 0 only.
- Timeout: a counter resets on entering ARM, WR_RISE, WR_FALL or FINISH, and counts while waiting in them. On reaching TIMEOUT-1: error=1, drop sst_we_reg and sst_act, busy=0, done pulse, go IDLE.
  - Timeout does not apply to stream stalls (RD_HOLD, WR_DATA wait indefinitely).
- start while busy is ignored. dir is sampled only with an accepted start.
- start and rst in the same clk: rst wins.
- sst_we_reg is never high outside WR_RISE/WR_FALL. sst_act is always high while busy.

Decomposition:
- Shared package mmc3_sst_pkg:
  - state enum (IDLE, ARM, RD_SET, RD_CAP, RD_HOLD, WR_DATA, WR_RISE, WR_FALL, FINISH)
  - SST address constants: SST_BANK0=0, SST_R8000=8, SST_RA000=9, SST_RA001=10, SST_IRQ_BASE=16
- One sub-module m2_edge_sync (synchronizer plus rise/fall pulses, parameter M2_SYNC).

Test Plan:
- Save, REG_CNT=11, mapper regs preloaded (r8001[0..7]=0x10..0x17, r8000=0xC5, rA000=0x01, rA001=0x80), rd_ready=1 → stream 0x10..0x17,0xC5,0x01,0x80 in order, then done pulse, busy=0, error=0.
- Restore, REG_CNT=11, wr_data 0x20..0x2A with random wr_valid gaps, M2 period 37 clk → mapper reads back 0x20..0x2A. Each sst_we_reg spans exactly one detected rise and one fall, and sst_addr/sst_dato are stable while sst_we_reg=1.
- Save with rd_ready held low 500 clk on addr 3 → rd_data stays at the reg3 value, no timeout, and the walk resumes correctly.
- Restore with cpu_m2 stuck high, TIMEOUT=64 → error=1 and done pulse within 64+M2_SYNC+2 clk of entering WR_RISE; sst_act=0, sst_we_reg=0.
- rst asserted in WR_FALL at addr 5 → next clk: sst_we_reg=0, busy=0, no done. A subsequent start completes normally with error=0.
- start pulsed while busy with dir flipped → ignored; the original direction completes with exactly REG_CNT transfers.
